// File: rtl/uart_bram_pkg.sv
// uart_bram_pkg: FSM state and host protocol bytes shared by the UART BRAM read and write paths
package uart_bram_pkg;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, REPLY, WAIT_TX} state_t;
  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_READ  = 8'h5A;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
endpackage

// File: rtl/uart_bram_writer_if.sv
// uart_bram_writer_if: UART rx/tx handshake and BRAM write port of the writer
// rx_data/rx_valid: receiver byte strobe; tx_busy/tx_data/tx_start: transmitter handshake
// bram_ce/bram_wre/bram_ad/bram_din: single-port BRAM write side
interface uart_bram_writer_if #(parameter int ADDR_W = 4);
  logic [7:0] rx_data;
  logic rx_valid;
  logic tx_busy;
  logic [7:0] tx_data;
  logic tx_start;
  logic bram_ce;
  logic bram_wre;
  logic [ADDR_W-1:0] bram_ad;
  logic [7:0] bram_din;
  modport master(input rx_data, rx_valid, tx_busy, output tx_data, tx_start, bram_ce, bram_wre, bram_ad, bram_din);
  modport slave(output rx_data, rx_valid, tx_busy, input tx_data, tx_start, bram_ce, bram_wre, bram_ad, bram_din);
endinterface

// File: rtl/uart_reply_sender.sv
// uart_reply_sender: holds a reply byte and runs the tx_start / tx_busy handshake with a 4-cycle guard
// i_load/i_byte: capture reply byte; i_reply/i_wait: caller is in REPLY / WAIT_TX
// i_tx_busy: transmitter busy; o_tx_data/o_tx_start: to transmitter; o_done: reply finished
module uart_reply_sender (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_reply,
  input  logic       i_wait,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_done
);
  logic [7:0] r_tx_data;
  logic r_seen;
  logic [1:0] r_guard;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_data <= '0;
      r_seen <= 1'b0;
      r_guard <= '0;
    end else begin
      if (i_load) r_tx_data <= i_byte;
      r_seen <= i_wait & (r_seen | i_tx_busy);
      r_guard <= i_wait ? r_guard + 2'd1 : '0;
    end
  end
  // a transmitter that never raises busy is given up on in the 4th WAIT_TX cycle
  assign o_tx_data = r_tx_data;
  assign o_tx_start = i_reply & ~i_tx_busy;
  assign o_done = i_wait & ~i_tx_busy & (r_seen | r_guard == 2'd3);
endmodule

// File: rtl/uart_bram_writer.sv
// uart_bram_writer: parses A5/addr/data UART frames into single BRAM writes and replies ACK or NAK
// clk/reset: 27 MHz clock, sync active-high reset; bus: UART handshake and BRAM write port
// busy: not IDLE; write_count: successful writes, wrapping
module uart_bram_writer #(
  parameter int ADDR_W = 4,
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0] CMD_WRITE = uart_bram_pkg::CMD_WRITE,
  parameter logic [7:0] ACK_BYTE = uart_bram_pkg::ACK_BYTE,
  parameter logic [7:0] NAK_BYTE = uart_bram_pkg::NAK_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic clk,
  input  logic reset,
  uart_bram_writer_if.master bus,
  output logic busy,
  output logic [15:0] write_count
);
  import uart_bram_pkg::*;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_state, w_next;
  logic r_addr_ok;
  logic [ADDR_W-1:0] r_bram_ad;
  logic [7:0] r_bram_din;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_write_count;
  logic w_load, w_timeout, w_in_frame, w_tx_start, w_done;
  logic [7:0] w_byte;
  assign w_in_frame = r_state == GET_ADDR || r_state == GET_DATA;
  assign w_timeout = w_in_frame && !bus.rx_valid && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_byte = NAK_BYTE;
    case (r_state)
      IDLE: if (bus.rx_valid) begin
        w_next = bus.rx_data == CMD_WRITE ? GET_ADDR : REPLY;
        w_load = bus.rx_data != CMD_WRITE;
      end
      GET_ADDR: begin
        w_next = bus.rx_valid ? GET_DATA : w_timeout ? REPLY : GET_ADDR;
        w_load = w_timeout;
      end
      // a bad address still consumes its data byte so the host stays frame-aligned
      GET_DATA: begin
        w_next = bus.rx_valid ? (r_addr_ok ? WRITE : REPLY) : w_timeout ? REPLY : GET_DATA;
        w_load = w_timeout | (bus.rx_valid & ~r_addr_ok);
      end
      WRITE: begin
        w_next = REPLY;
        w_load = 1'b1;
        w_byte = ACK_BYTE;
      end
      REPLY: w_next = w_tx_start ? WAIT_TX : REPLY;
      WAIT_TX: w_next = w_done ? IDLE : WAIT_TX;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr_ok <= 1'b0;
      r_bram_ad <= '0;
      r_bram_din <= '0;
      r_cnt <= '0;
      r_write_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_in_frame && !bus.rx_valid) ? r_cnt + 1'b1 : '0;
      if (r_state == GET_ADDR && bus.rx_valid) begin
        r_addr_ok <= 32'(bus.rx_data) < DEPTH;
        r_bram_ad <= bus.rx_data[ADDR_W-1:0];
      end
      if (r_state == GET_DATA && bus.rx_valid) r_bram_din <= bus.rx_data;
      if (r_state == WRITE) r_write_count <= r_write_count + 16'd1;
    end
  end
  uart_reply_sender u_reply (
    .clk(clk),
    .reset(reset),
    .i_load(w_load),
    .i_byte(w_byte),
    .i_reply(r_state == REPLY),
    .i_wait(r_state == WAIT_TX),
    .i_tx_busy(bus.tx_busy),
    .o_tx_data(bus.tx_data),
    .o_tx_start(w_tx_start),
    .o_done(w_done)
  );
  assign bus.tx_start = w_tx_start;
  assign bus.bram_ce = r_state == WRITE;
  assign bus.bram_wre = r_state == WRITE;
  assign bus.bram_ad = r_bram_ad;
  assign bus.bram_din = r_bram_din;
  assign busy = r_state != IDLE;
  assign write_count = r_write_count;
endmodule

// File: tb/tb_uart_bram_writer.sv
// tb_uart_bram_writer: directed frames against a write/reply scoreboard with a simple transmitter model
module tb_uart_bram_writer;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int TMO = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [15:0] write_count;
  logic model_busy = 1'b0;
  logic ext_busy = 1'b0;
  logic model_en = 1'b1;
  int ntests = 0;
  int nfail = 0;
  int exp_cnt = 0;
  logic [11:0] wq[$];
  logic [7:0] rq[$];
  uart_bram_writer_if #(.ADDR_W(4)) bus();
  uart_bram_writer #(.ADDR_W(4), .DEPTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .write_count(write_count)
  );
  assign bus.tx_busy = model_busy | ext_busy;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (bus.bram_wre || bus.bram_ce) begin
      chk("ce_eq_wre", 32'(bus.bram_ce), 32'(bus.bram_wre));
      chk("write_pending", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) chk("write_ad_din", 32'({bus.bram_ad, bus.bram_din}), 32'(wq.pop_front()));
    end
    if (bus.tx_start) begin
      chk("tx_start_busy_low", 32'(bus.tx_busy), 0);
      chk("reply_pending", 32'(rq.size() > 0), 1);
      if (rq.size() > 0) chk("reply_byte", 32'(bus.tx_data), 32'(rq.pop_front()));
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.tx_start && model_en && !reset) begin
      @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (5) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end
  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_count"}, 32'(write_count), 32'(exp_cnt));
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ce", 32'(bus.bram_ce), 0);
    chk("rst_wre", 32'(bus.bram_wre), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_ad", 32'(bus.bram_ad), 0);
    chk("rst_din", 32'(bus.bram_din), 0);
    chk("rst_count", 32'(write_count), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset();
    reset = 1'b0;
    // basic write then ACK
    wq.push_back({4'h3, 8'h5C}); rq.push_back(ACK); exp_cnt++;
    send(8'hA5); send(8'h03); send(8'h5C);
    wait_idle("frame_a");
    // out-of-range address: data consumed, NAK, no write
    rq.push_back(NAK);
    send(8'hA5); send(8'h12); send(8'h77);
    wait_idle("bad_addr");
    // stray byte then a good frame at the top address
    rq.push_back(NAK);
    send(8'h41);
    wait_idle("stray");
    wq.push_back({4'hF, 8'hFF}); rq.push_back(ACK); exp_cnt++;
    send(8'hA5); send(8'h0F); send(8'hFF);
    wait_idle("frame_f");
    // timeout in GET_DATA: reply starts the cycle after the 100th idle cycle
    rq.push_back(NAK);
    send(8'hA5); send(8'h02);
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TMO + 1));
    @(posedge clk);
    #1 wait_idle("timeout");
    wq.push_back({4'h4, 8'h9C}); rq.push_back(ACK); exp_cnt++;
    send(8'hA5); send(8'h04); send(8'h9C);
    wait_idle("after_timeout");
    // byte arriving in the very cycle the timeout would fire wins
    wq.push_back({4'h6, 8'h2B}); rq.push_back(ACK); exp_cnt++;
    send(8'hA5);
    repeat (TMO - 1) @(posedge clk);
    #1 send(8'h06); send(8'h2B);
    wait_idle("rx_beats_timeout");
    // transmitter busy for 50 cycles: ACK waits, bytes meanwhile are dropped
    ext_busy = 1'b1;
    wq.push_back({4'h5, 8'h33}); rq.push_back(ACK); exp_cnt++;
    send(8'hA5); send(8'h05); send(8'h33);
    repeat (10) @(posedge clk);
    #1 send(8'hA5); send(8'h01); send(8'h11);
    repeat (35) @(posedge clk);
    #1 chk("held_reply_pending", 32'(rq.size()), 1);
    ext_busy = 1'b0;
    wait_idle("tx_held");
    // transmitter never answers: guard releases the FSM
    model_en = 1'b0;
    rq.push_back(NAK);
    send(8'h00);
    @(negedge clk);
    chk("guard_tx_start", 32'(bus.tx_start), 1);
    repeat (5) @(negedge clk);
    chk("guard_released", 32'(busy), 0);
    model_en = 1'b1;
    @(posedge clk);
    #1 wait_idle("guard");
    // reset in GET_DATA together with the data strobe
    send(8'hA5); send(8'h07);
    reset = 1'b1;
    bus.rx_data = 8'h3C;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    exp_cnt = 0;
    check_reset();
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 wait_idle("rst_get_data");
    // reset while a NAK is waiting for the transmitter
    ext_busy = 1'b1;
    send(8'h41);
    @(negedge clk);
    chk("reply_loaded", 32'(bus.tx_data), 32'(NAK));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 check_reset();
    reset = 1'b0;
    ext_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1 wait_idle("rst_reply");
    chk("write_q_empty", 32'(wq.size()), 0);
    chk("reply_q_empty", 32'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
